// File: rtl/multisim_quasi_static_push_mux.sv
// multisim_quasi_static_push_mux: pushes changed quasi-static channel values over a valid/ready transport.
// Ports:
//   clk, rst      - single clock, synchronous active-high reset
//   ch_data       - N_CHANNELS packed channel values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   tx_valid      - an update is offered (registered)
//   tx_ready      - transport accepts the offered update
//   tx_channel    - index of the offered channel
//   tx_data       - value of the offered channel, frozen while offered
//   pending       - per-channel "differs from last sent or forced" flags
//   update_count  - accepted transfers since reset, wrapping
module multisim_quasi_static_push_mux #(
    parameter int N_CHANNELS     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REFRESH_PERIOD = 0,
    localparam int CW            = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] ch_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic [CW-1:0]                    tx_channel,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic [N_CHANNELS-1:0]            pending,
    output logic [31:0]                      update_count
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   sent_q [N_CHANNELS];
    logic [DATA_WIDTH-1:0]   sent_d [N_CHANNELS];
    logic [N_CHANNELS-1:0]   force_q, force_d;
    logic [CW-1:0]           last_grant_q, last_grant_d;
    logic [CW-1:0]           tx_channel_q, tx_channel_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [31:0]             update_count_q, update_count_d;
    logic [CW-1:0]           sel;
    logic                    sel_found;
    logic                    hs;
    logic                    refresh_wrap;

    always_comb begin
        pending = '0;
        for (int i = 0; i < N_CHANNELS; i++)
            pending[i] = (ch_data[i*DATA_WIDTH +: DATA_WIDTH] != sent_q[i]) | force_q[i];
    end

    // Round-robin: first pending channel at or after last_grant+1, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            idx = (int'(last_grant_q) + 1 + k) % N_CHANNELS;
            if (!sel_found && pending[idx]) begin
                sel       = CW'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign hs = (state_q == OFFER) & tx_ready;

    always_comb begin
        state_d        = state_q;
        tx_channel_d   = tx_channel_q;
        tx_data_d      = tx_data_q;
        last_grant_d   = last_grant_q;
        update_count_d = update_count_q;
        sent_d         = sent_q;
        force_d        = force_q;
        if (state_q == IDLE && sel_found) begin
            state_d      = OFFER;
            tx_channel_d = sel;
            tx_data_d    = ch_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (hs) begin
            state_d                = IDLE;
            sent_d[tx_channel_q]   = tx_data_q;
            force_d[tx_channel_q]  = 1'b0;
            last_grant_d           = tx_channel_q;
            update_count_d         = update_count_q + 32'd1;
        end
        // A refresh landing on a handshake edge must still force that channel.
        if (refresh_wrap)
            force_d = '1;
    end

    generate
        if (REFRESH_PERIOD > 0) begin : g_refresh
            localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
            assign refresh_wrap  = refresh_cnt_q == RW'(REFRESH_PERIOD - 1);
            assign refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + 1'b1;
            always_ff @(posedge clk) begin
                if (rst)
                    refresh_cnt_q <= '0;
                else
                    refresh_cnt_q <= refresh_cnt_d;
            end
        end else begin : g_no_refresh
            assign refresh_wrap = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            tx_channel_q   <= '0;
            tx_data_q      <= '0;
            last_grant_q   <= CW'(N_CHANNELS - 1);
            update_count_q <= '0;
            sent_q         <= '{default: '0};
            force_q        <= '1;
        end else begin
            state_q        <= state_d;
            tx_channel_q   <= tx_channel_d;
            tx_data_q      <= tx_data_d;
            last_grant_q   <= last_grant_d;
            update_count_q <= update_count_d;
            sent_q         <= sent_d;
            force_q        <= force_d;
        end
    end

    assign tx_valid     = state_q == OFFER;
    assign tx_channel   = tx_channel_q;
    assign tx_data      = tx_data_q;
    assign update_count = update_count_q;
endmodule

// File: tb/tb_multisim_quasi_static_push_mux.sv
// tb_multisim_quasi_static_push_mux: directed checks of the push mux, with and without refresh.
module tb_multisim_quasi_static_push_mux;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ch_data;
    logic         tx_ready;
    logic         tx_valid, r_tx_valid;
    logic [1:0]   tx_channel, r_tx_channel;
    logic [31:0]  tx_data, r_tx_data;
    logic [3:0]   pending, r_pending;
    logic [31:0]  update_count, r_update_count;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    multisim_quasi_static_push_mux #(.N_CHANNELS(4), .DATA_WIDTH(32), .REFRESH_PERIOD(0)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_channel(tx_channel), .tx_data(tx_data), .pending(pending), .update_count(update_count)
    );

    multisim_quasi_static_push_mux #(.N_CHANNELS(4), .DATA_WIDTH(32), .REFRESH_PERIOD(16)) dut_r (
        .clk(clk), .rst(rst), .ch_data(ch_data), .tx_valid(r_tx_valid), .tx_ready(1'b1),
        .tx_channel(r_tx_channel), .tx_data(r_tx_data), .pending(r_pending), .update_count(r_update_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        ch_data[i*32 +: 32] = v;
    endtask

    task automatic expect_offer(input string tag, input int ch, input logic [31:0] d);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_chan"}, 32'(tx_channel), 32'(ch));
        check({tag, "_data"}, tx_data, d);
    endtask

    initial begin
        rst      = 1'b1;
        ch_data  = '0;
        tx_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_chan", 32'(tx_channel), 32'd0);
        check("rst_data", tx_data, 32'd0);
        check("rst_count", update_count, 32'd0);
        check("rst_pending", 32'(pending), 32'hF);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tick();
            expect_offer("sync", i, 32'h0);
            tick();
            check("sync_idle", 32'(tx_valid), 32'd0);
            check("sync_count", update_count, 32'(i + 1));
        end
        tick();
        check("sync_quiet", 32'(tx_valid), 32'd0);
        check("sync_pending", 32'(pending), 32'h0);

        set_ch(2, 32'hDEADBEEF);
        tick();
        expect_offer("single", 2, 32'hDEADBEEF);
        tick();
        check("single_count", update_count, 32'd5);
        check("single_pending", 32'(pending), 32'h0);
        tick();
        check("single_once", 32'(tx_valid), 32'd0);
        check("single_count2", update_count, 32'd5);

        tx_ready = 1'b0;
        set_ch(1, 32'h1);
        tick();
        expect_offer("bp_first", 1, 32'h1);
        set_ch(1, 32'h2);
        set_ch(3, 32'h5);
        tick();
        set_ch(3, 32'h6);
        tick();
        set_ch(3, 32'h7);
        for (int i = 0; i < 8; i++) tick();
        expect_offer("bp_hold", 1, 32'h1);
        check("bp_count", update_count, 32'd5);
        check("bp_pending", 32'(pending), 32'hA);
        tx_ready = 1'b1;
        tick();
        check("bp_hs_count", update_count, 32'd6);
        check("bp_hs_valid", 32'(tx_valid), 32'd0);
        check("bp_hs_pending", 32'(pending), 32'hA);
        tick();
        expect_offer("bp_ch3", 3, 32'h7);
        tick();
        tick();
        expect_offer("bp_ch1", 1, 32'h2);
        tick();
        check("bp_count_end", update_count, 32'd8);
        check("bp_pending_end", 32'(pending), 32'h0);

        for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i));
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_offer("rr", (k + 2) % 4, 32'hA0 + 32'((k + 2) % 4));
            tick();
            check("rr_count", update_count, 32'(9 + k));
        end

        tx_ready = 1'b0;
        set_ch(0, 32'hB0);
        tick();
        expect_offer("mid_offer", 0, 32'hB0);
        rst      = 1'b1;
        tx_ready = 1'b1;
        tick();
        check("mid_rst_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_count", update_count, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_offer("resync", i, i == 0 ? 32'hB0 : 32'hA0 + 32'(i));
            tick();
            check("resync_count", update_count, 32'(i + 1));
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("ref_sync_count", r_update_count, 32'd4);
        check("ref_sync_pending", 32'(r_pending), 32'h0);
        for (int i = 0; i < 7; i++) tick();
        check("ref_prewrap_pending", 32'(r_pending), 32'h0);
        tick();
        check("ref_wrap_pending", 32'(r_pending), 32'hF);
        check("ref_wrap_count", r_update_count, 32'd4);
        tick();
        check("ref_offer_valid", 32'(r_tx_valid), 32'd1);
        check("ref_offer_chan", 32'(r_tx_channel), 32'd0);
        check("ref_offer_data", r_tx_data, 32'hB0);
        for (int i = 0; i < 7; i++) tick();
        check("ref_count1", r_update_count, 32'd8);
        check("ref_pending1", 32'(r_pending), 32'h0);
        for (int i = 0; i < 8; i++) tick();
        check("ref_wrap2_pending", 32'(r_pending), 32'hF);
        check("norefresh_pending", 32'(pending), 32'h0);
        check("norefresh_count", update_count, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multisim_quasi_static_push_mux.md
MULTISIM_QUASI_STATIC_PUSH_MUX -- requirements
Module: multisim_quasi_static_push_mux

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4, number of quasi-static input channels (>=1).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, bits per channel.
REQ-003 SHALL have parameter REFRESH_PERIOD, default 0, cycles between forced full resends; 0 disables refresh.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port ch_data  input  N_CHANNELS*DATA_WIDTH  channel values; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port tx_valid  output  1  update offered to transport.
REQ-008 SHALL have port tx_ready  input  1  transport accepts update.
REQ-009 SHALL have port tx_channel  output  CW=max(1,$clog2(N_CHANNELS))  index of offered channel.
REQ-010 SHALL have port tx_data  output  DATA_WIDTH  offered channel value.
REQ-011 SHALL have port pending  output  N_CHANNELS  per-channel "needs send" flags.
REQ-012 SHALL have port update_count  output  32  accepted transfers since reset, wraps 0xFFFFFFFF->0.

Function
REQ-013 SHALL keep per channel a sent register (last accepted value) and a force bit.
REQ-014 SHALL compute pending[i] = (ch_data[i] != sent[i]) | force[i], combinationally.
REQ-015 SHALL implement FSM IDLE/OFFER; tx_valid = (state==OFFER), registered.
REQ-016 IDLE with any pending at edge k SHALL select a channel, latch tx_channel and tx_data = ch_data[sel] sampled at edge k, enter OFFER; tx_valid high in the cycle after edge k.
REQ-017 IDLE with no pending SHALL stay IDLE; tx_channel/tx_data hold previous values.
REQ-018 Selection SHALL be round-robin: first pending index searching upward from last_grant+1 modulo N_CHANNELS; last_grant resets to N_CHANNELS-1 so channel 0 wins first.
REQ-019 In OFFER, tx_channel and tx_data SHALL stay stable until handshake, regardless of ch_data changes.
REQ-020 On edge with tx_valid & tx_ready: sent[tx_channel] <= tx_data, force[tx_channel] <= 0, last_grant <= tx_channel, update_count += 1, state <= IDLE.
REQ-021 Channel changes during OFFER SHALL coalesce: only the value present at the next selection is sent; intermediate values are dropped.
REQ-022 If the accepted channel changed during OFFER, it SHALL remain pending (ch_data != sent) and be resent later in round-robin order.
REQ-023 Throughput SHALL be one transfer per two cycles maximum (OFFER, IDLE); no combinational path tx_ready->tx_valid.
REQ-024 With REFRESH_PERIOD>0 a counter SHALL count 0..REFRESH_PERIOD-1 and, on wrap, set all force bits; a force set coinciding with a handshake on channel j SHALL leave force[j]=1 (set wins).
REQ-025 With REFRESH_PERIOD=0 the refresh counter SHALL be absent/inert and force bits only set by reset.

Reset
REQ-026 While rst high: state=IDLE, tx_valid=0, tx_channel=0, tx_data=0, sent[*]=0, force[*]=1, last_grant=N_CHANNELS-1, update_count=0, refresh counter=0.
REQ-027 rst asserted during OFFER SHALL drop tx_valid on the next edge with no handshake counted; after release all channels resent (initial sync).
REQ-028 tx_ready SHALL be ignored while rst high.

Verification (N_CHANNELS=4, DATA_WIDTH=32, REFRESH_PERIOD=0 unless stated)
REQ-029 Initial sync: release rst, ch_data all 0, tx_ready=1 -> transfers ch0,1,2,3 each data 0x0 on alternate cycles, then idle; update_count=4, pending=0000.
REQ-030 Single change: after sync set ch2=0xDEADBEEF -> tx_valid next cycle, tx_channel=2, tx_data=0xDEADBEEF; exactly one transfer, update_count=5.
REQ-031 Backpressure/coalescing: tx_ready=0; ch1=0x1 offered; ch1->0x2 and ch3 0x5,0x6,0x7 while held 10 cycles; tx_data stays 0x1; tx_ready=1 -> transfers (1,0x1),(3,0x7),(1,0x2) in that order.
REQ-032 Round-robin: last_grant=1, all four channels change same cycle -> grant order 2,3,0,1.
REQ-033 Refresh: REFRESH_PERIOD=16, inputs static after sync -> every 16 cycles four transfers of current values, pending=1111 at wrap.
REQ-034 Reset mid-offer: rst one cycle while tx_valid=1, tx_ready=0 -> tx_valid=0 next cycle, update_count=0, then initial sync sequence of REQ-029 with current ch_data.
